// File: rtl/overlay_sprite_fader.sv
// Full-screen indexed-colour overlay with integer upscaling, optional transparency
// and a frame-paced fade-in / fade-out / blink controller.
module overlay_sprite_fader #(
    parameter int IMG_W        = 320,
    parameter int IMG_H        = 360,
    parameter int X0           = 160,
    parameter int Y0           = 60,
    parameter int SCALE_LOG2   = 0,
    parameter int IDX_W        = 1,
    parameter int ADDR_W       = 17,
    parameter int FADE_FRAMES  = 2,
    parameter int BLINK_FRAMES = 0,
    parameter int TRANSP_EN    = 0,
    parameter int TRANSP_IDX   = 0
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              show,
    input  logic [3:0]        bg_red,
    input  logic [3:0]        bg_green,
    input  logic [3:0]        bg_blue,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              busy,
    output logic              visible
);

    localparam int FCNT_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FADE_FRAMES - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);
    localparam int BOX_W = IMG_W << SCALE_LOG2;
    localparam int BOX_H = IMG_H << SCALE_LOG2;
    localparam logic [IDX_W-1:0] TRANSP_VAL = IDX_W'(TRANSP_IDX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FADE_IN,
        ST_SHOW,
        ST_FADE_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          level_q, level_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                blink_on_q, blink_on_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic                in_box_s1_q, in_box_s1_d, in_box_s2_q, in_box_s2_d;
    logic                blank_s1_q, blank_s1_d, blank_s2_q, blank_s2_d;
    logic [11:0]         bg_s1_q, bg_s1_d, bg_s2_q, bg_s2_d;
    logic [11:0]         rgb_q, rgb_d;

    logic signed [10:0]  dx, dy;
    logic signed [31:0]  dx_ext, dy_ext;
    logic [31:0]         addr_full;
    logic                in_box;
    logic                frame_tick;
    logic                step;
    logic                pass_bg;

    function automatic logic [3:0] scale_chan(input logic [3:0] c, input logic [4:0] lv);
        logic [8:0] p;
        p = {5'b0, c} * {4'b0, lv};
        return 4'(p >> 4);
    endfunction

    // Stage 1: box test and ROM address for the pixel being presented now.
    always_comb begin
        dx        = $signed({1'b0, DrawX}) - $signed(11'(X0));
        dy        = $signed({1'b0, DrawY}) - $signed(11'(Y0));
        dx_ext    = {{21{dx[10]}}, dx};
        dy_ext    = {{21{dy[10]}}, dy};
        in_box    = (dx_ext >= 0) && (dx_ext < BOX_W) && (dy_ext >= 0) && (dy_ext < BOX_H);
        addr_full = 32'((dy_ext >>> SCALE_LOG2) * IMG_W + (dx_ext >>> SCALE_LOG2));
        rom_addr_d  = in_box ? ADDR_W'(addr_full) : '0;
        in_box_s1_d = in_box;
        blank_s1_d  = blank;
        bg_s1_d     = {bg_red, bg_green, bg_blue};
        in_box_s2_d = in_box_s1_q;
        blank_s2_d  = blank_s1_q;
        bg_s2_d     = bg_s1_q;
    end

    assign frame_tick = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign step       = frame_tick && (fcnt_q == FCNT_LAST);

    // A direction change takes priority over a coincident step, so the step is dropped.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        blink_on_d = blink_on_q;
        bcnt_d     = bcnt_q;
        fcnt_d     = fcnt_q;
        if (frame_tick) begin
            fcnt_d = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                level_d    = 5'd0;
                blink_on_d = 1'b1;
                bcnt_d     = '0;
                if (show) begin
                    state_d = ST_FADE_IN;
                end
            end
            ST_FADE_IN: begin
                blink_on_d = 1'b1;
                bcnt_d     = '0;
                if (!show) begin
                    state_d = ST_FADE_OUT;
                end else if (step) begin
                    level_d = level_q + 5'd1;
                    if (level_q == 5'd15) begin
                        state_d = ST_SHOW;
                    end
                end
            end
            ST_SHOW: begin
                level_d = 5'd16;
                if (!show) begin
                    state_d    = ST_FADE_OUT;
                    blink_on_d = 1'b1;
                    bcnt_d     = '0;
                end else if ((BLINK_FRAMES > 0) && frame_tick) begin
                    if (bcnt_q == BCNT_LAST) begin
                        bcnt_d     = '0;
                        blink_on_d = !blink_on_q;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            ST_FADE_OUT: begin
                if (show) begin
                    state_d = ST_FADE_IN;
                end else if (step) begin
                    level_d = level_q - 5'd1;
                    if (level_q == 5'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                level_d = 5'd0;
            end
        endcase
        if (state_d != state_q) begin
            fcnt_d = '0;
        end
    end

    // Output stage: rom_q and the palette now belong to the pixel held in stage 2.
    always_comb begin
        pass_bg = !in_box_s2_q || (state_q == ST_IDLE) || !blink_on_q ||
                  ((TRANSP_EN != 0) && (rom_q == TRANSP_VAL));
        if (!blank_s2_q) begin
            rgb_d = 12'h000;
        end else if (pass_bg) begin
            rgb_d = bg_s2_q;
        end else begin
            rgb_d = {scale_chan(pal_red, level_q), scale_chan(pal_green, level_q),
                     scale_chan(pal_blue, level_q)};
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            level_q     <= 5'd0;
            fcnt_q      <= '0;
            bcnt_q      <= '0;
            blink_on_q  <= 1'b1;
            rom_addr_q  <= '0;
            in_box_s1_q <= 1'b0;
            blank_s1_q  <= 1'b0;
            bg_s1_q     <= 12'h000;
            in_box_s2_q <= 1'b0;
            blank_s2_q  <= 1'b0;
            bg_s2_q     <= 12'h000;
            rgb_q       <= 12'h000;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            fcnt_q      <= fcnt_d;
            bcnt_q      <= bcnt_d;
            blink_on_q  <= blink_on_d;
            rom_addr_q  <= rom_addr_d;
            in_box_s1_q <= in_box_s1_d;
            blank_s1_q  <= blank_s1_d;
            bg_s1_q     <= bg_s1_d;
            in_box_s2_q <= in_box_s2_d;
            blank_s2_q  <= blank_s2_d;
            bg_s2_q     <= bg_s2_d;
            rgb_q       <= rgb_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pal_index = rom_q;
    assign red       = rgb_q[11:8];
    assign green     = rgb_q[7:4];
    assign blue      = rgb_q[3:0];
    assign busy      = (state_q == ST_FADE_IN) || (state_q == ST_FADE_OUT);
    assign visible   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_overlay_sprite_fader.sv
// Directed bench for overlay_sprite_fader: three instances (default image, scaled
// transparent image, blinking image) driven with shared raster inputs.
module tb_overlay_sprite_fader;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        blank;
    logic [3:0]  bg_red, bg_green, bg_blue;
    logic        show_m, show_s, show_b;

    logic [16:0] rom_addr_m, rom_addr_s, rom_addr_b;
    logic        rom_q_m, rom_q_s, rom_q_b;
    logic        pal_index_m, pal_index_s, pal_index_b;
    logic [3:0]  pal_r_m, pal_g_m, pal_b_m, pal_r_s, pal_g_s, pal_b_s, pal_r_b, pal_g_b, pal_b_b;
    logic [3:0]  red_m, green_m, blue_m, red_s, green_s, blue_s, red_b, green_b, blue_b;
    logic        busy_m, busy_s, busy_b, visible_m, visible_s, visible_b;

    int checks = 0;
    int errors = 0;

    always #5 vga_clk = ~vga_clk;

    overlay_sprite_fader #(.FADE_FRAMES(1)) u_main (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .show(show_m), .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .rom_addr(rom_addr_m), .rom_q(rom_q_m), .pal_index(pal_index_m),
        .pal_red(pal_r_m), .pal_green(pal_g_m), .pal_blue(pal_b_m),
        .red(red_m), .green(green_m), .blue(blue_m), .busy(busy_m), .visible(visible_m)
    );

    overlay_sprite_fader #(.IMG_W(4), .IMG_H(2), .X0(0), .Y0(0), .SCALE_LOG2(1),
                           .FADE_FRAMES(1), .TRANSP_EN(1), .TRANSP_IDX(0)) u_scale (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .show(show_s), .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .rom_addr(rom_addr_s), .rom_q(rom_q_s), .pal_index(pal_index_s),
        .pal_red(pal_r_s), .pal_green(pal_g_s), .pal_blue(pal_b_s),
        .red(red_s), .green(green_s), .blue(blue_s), .busy(busy_s), .visible(visible_s)
    );

    overlay_sprite_fader #(.FADE_FRAMES(2), .BLINK_FRAMES(3)) u_blink (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .show(show_b), .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .rom_addr(rom_addr_b), .rom_q(rom_q_b), .pal_index(pal_index_b),
        .pal_red(pal_r_b), .pal_green(pal_g_b), .pal_blue(pal_b_b),
        .red(red_b), .green(green_b), .blue(blue_b), .busy(busy_b), .visible(visible_b)
    );

    // ROM image: index = address bit 0. Palette: index 1 = FA5, index 0 = 842.
    function automatic logic [11:0] pal_lut(input logic idx);
        return idx ? 12'hFA5 : 12'h842;
    endfunction

    always_ff @(posedge vga_clk) begin
        rom_q_m <= rom_addr_m[0];
        rom_q_s <= rom_addr_s[0];
        rom_q_b <= rom_addr_b[0];
    end

    always_comb begin
        {pal_r_m, pal_g_m, pal_b_m} = pal_lut(pal_index_m);
        {pal_r_s, pal_g_s, pal_b_s} = pal_lut(pal_index_s);
        {pal_r_b, pal_g_b, pal_b_b} = pal_lut(pal_index_b);
    end

    function automatic logic [11:0] faded(input logic [11:0] c, input int lv);
        int r, g, b;
        r = int'(c[11:8]) * lv / 16;
        g = int'(c[7:4]) * lv / 16;
        b = int'(c[3:0]) * lv / 16;
        return {r[3:0], g[3:0], b[3:0]};
    endfunction

    typedef struct {
        int          inst;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        b;
        logic [11:0] bg;
        logic [11:0] exp_rgb;
        int          exp_addr;
    } vec_t;

    function automatic vec_t mk(input int inst, input int x, input int y, input logic b,
                                input logic [11:0] bg, input logic [11:0] rgb, input int addr);
        vec_t v;
        v.inst = inst; v.x = 10'(x); v.y = 10'(y); v.b = b;
        v.bg = bg; v.exp_rgb = rgb; v.exp_addr = addr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int x, input int y, input logic b, input logic [11:0] bg);
        @(negedge vga_clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        {bg_red, bg_green, bg_blue} = bg;
        repeat (3) @(negedge vga_clk);
    endtask

    task automatic frameTick();
        @(negedge vga_clk);
        DrawX = 10'd0; DrawY = 10'd0; blank = 1'b0;
        @(negedge vga_clk);
        DrawX = 10'd700; DrawY = 10'd500; blank = 1'b0;
    endtask

    task automatic runTable(input vec_t vecs[$], input string tag);
        foreach (vecs[i]) begin
            applyStimulus(int'(vecs[i].x), int'(vecs[i].y), vecs[i].b, vecs[i].bg);
            if (vecs[i].inst == 0) begin
                checkOutput($sformatf("%s%0d_rgb", tag, i), int'({red_m, green_m, blue_m}), int'(vecs[i].exp_rgb));
                checkOutput($sformatf("%s%0d_addr", tag, i), int'(rom_addr_m), vecs[i].exp_addr);
            end else begin
                checkOutput($sformatf("%s%0d_rgb", tag, i), int'({red_s, green_s, blue_s}), int'(vecs[i].exp_rgb));
                checkOutput($sformatf("%s%0d_addr", tag, i), int'(rom_addr_s), vecs[i].exp_addr);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t idle_vecs[$];
        vec_t show_vecs[$];

        idle_vecs.push_back(mk(0, 160, 60, 1'b1, 12'h333, 12'h333, 0));
        idle_vecs.push_back(mk(0, 200, 100, 1'b1, 12'h333, 12'h333, 12840));
        idle_vecs.push_back(mk(0, 10, 10, 1'b1, 12'h333, 12'h333, 0));
        idle_vecs.push_back(mk(0, 300, 200, 1'b0, 12'h333, 12'h000, 44940));
        idle_vecs.push_back(mk(0, 479, 419, 1'b1, 12'h333, 12'h333, 115199));
        idle_vecs.push_back(mk(0, 480, 60, 1'b1, 12'h333, 12'h333, 0));
        idle_vecs.push_back(mk(0, 160, 420, 1'b1, 12'h333, 12'h333, 0));
        idle_vecs.push_back(mk(0, 159, 60, 1'b1, 12'h333, 12'h333, 0));
        idle_vecs.push_back(mk(1, 1, 0, 1'b1, 12'h333, 12'h333, 0));
        idle_vecs.push_back(mk(1, 2, 0, 1'b1, 12'h333, 12'h333, 1));
        idle_vecs.push_back(mk(1, 3, 0, 1'b1, 12'h333, 12'h333, 1));
        idle_vecs.push_back(mk(1, 4, 0, 1'b1, 12'h333, 12'h333, 2));
        idle_vecs.push_back(mk(1, 7, 0, 1'b1, 12'h333, 12'h333, 3));
        idle_vecs.push_back(mk(1, 0, 2, 1'b1, 12'h333, 12'h333, 4));
        idle_vecs.push_back(mk(1, 7, 3, 1'b1, 12'h333, 12'h333, 7));
        idle_vecs.push_back(mk(1, 8, 0, 1'b1, 12'h333, 12'h333, 0));
        idle_vecs.push_back(mk(1, 0, 4, 1'b0, 12'h333, 12'h000, 0));

        show_vecs.push_back(mk(1, 1, 0, 1'b1, 12'h5C7, 12'h5C7, 0));
        show_vecs.push_back(mk(1, 2, 0, 1'b1, 12'h5C7, 12'hFA5, 1));
        show_vecs.push_back(mk(1, 0, 2, 1'b1, 12'h5C7, 12'h5C7, 4));
        show_vecs.push_back(mk(1, 2, 3, 1'b1, 12'h5C7, 12'hFA5, 5));
        show_vecs.push_back(mk(1, 7, 1, 1'b1, 12'h5C7, 12'hFA5, 3));
        show_vecs.push_back(mk(1, 4, 1, 1'b1, 12'h5C7, 12'h5C7, 2));
        show_vecs.push_back(mk(1, 8, 0, 1'b1, 12'h5C7, 12'h5C7, 0));
        show_vecs.push_back(mk(1, 9, 1, 1'b0, 12'h5C7, 12'h000, 0));
        show_vecs.push_back(mk(0, 160, 60, 1'b1, 12'h5C7, 12'h842, 0));
        show_vecs.push_back(mk(0, 479, 419, 1'b1, 12'h5C7, 12'hFA5, 115199));
        show_vecs.push_back(mk(0, 161, 60, 1'b1, 12'h5C7, 12'hFA5, 1));
        show_vecs.push_back(mk(0, 480, 419, 1'b1, 12'h5C7, 12'h5C7, 0));

        reset_n = 1'b0;
        show_m = 1'b0; show_s = 1'b0; show_b = 1'b0;
        DrawX = 10'd700; DrawY = 10'd500; blank = 1'b0;
        {bg_red, bg_green, bg_blue} = 12'h333;
        repeat (3) @(negedge vga_clk);
        checkOutput("reset_rgb", int'({red_m, green_m, blue_m}), 0);
        checkOutput("reset_addr", int'(rom_addr_m), 0);
        checkOutput("reset_busy", int'(busy_m), 0);
        checkOutput("reset_visible", int'(visible_m), 0);
        reset_n = 1'b1;

        $display("[TB] idle pass-through and address table");
        runTable(idle_vecs, "idle");
        checkOutput("idle_visible", int'(visible_m), 0);

        $display("[TB] fade in, one level per frame");
        @(negedge vga_clk);
        show_m = 1'b1; show_s = 1'b1;
        for (int f = 1; f <= 16; f++) begin
            frameTick();
            applyStimulus(161, 60, 1'b1, 12'h5C7);
            checkOutput($sformatf("fadein%0d_rgb", f), int'({red_m, green_m, blue_m}), int'(faded(12'hFA5, f)));
            checkOutput($sformatf("fadein%0d_busy", f), int'(busy_m), (f < 16) ? 1 : 0);
        end
        checkOutput("show_visible", int'(visible_m), 1);

        $display("[TB] show state table");
        runTable(show_vecs, "show");

        $display("[TB] fade out to idle");
        @(negedge vga_clk);
        show_m = 1'b0;
        for (int f = 1; f <= 16; f++) begin
            frameTick();
            applyStimulus(161, 60, 1'b1, 12'h5C7);
            checkOutput($sformatf("fadeout%0d_rgb", f), int'({red_m, green_m, blue_m}),
                        (f < 16) ? int'(faded(12'hFA5, 16 - f)) : int'(12'h5C7));
            checkOutput($sformatf("fadeout%0d_busy", f), int'(busy_m), (f < 16) ? 1 : 0);
        end
        checkOutput("fadeout_visible", int'(visible_m), 0);

        $display("[TB] reversal at level 9 on a step frame");
        @(negedge vga_clk);
        show_m = 1'b1;
        for (int f = 1; f <= 9; f++) frameTick();
        applyStimulus(161, 60, 1'b1, 12'h5C7);
        checkOutput("rev_lvl9_rgb", int'({red_m, green_m, blue_m}), int'(faded(12'hFA5, 9)));
        @(negedge vga_clk);
        DrawX = 10'd0; DrawY = 10'd0; blank = 1'b0; show_m = 1'b0;
        @(negedge vga_clk);
        DrawX = 10'd700; DrawY = 10'd500;
        applyStimulus(161, 60, 1'b1, 12'h5C7);
        checkOutput("rev_hold_rgb", int'({red_m, green_m, blue_m}), int'(faded(12'hFA5, 9)));
        checkOutput("rev_hold_busy", int'(busy_m), 1);
        for (int f = 1; f <= 9; f++) begin
            frameTick();
            applyStimulus(161, 60, 1'b1, 12'h5C7);
            checkOutput($sformatf("rev%0d_rgb", f), int'({red_m, green_m, blue_m}),
                        (f < 9) ? int'(faded(12'hFA5, 9 - f)) : int'(12'h5C7));
            checkOutput($sformatf("rev%0d_busy", f), int'(busy_m), (f < 9) ? 1 : 0);
        end

        $display("[TB] two-frame fade steps and blink");
        @(negedge vga_clk);
        show_b = 1'b1;
        for (int t = 1; t <= 32; t++) begin
            frameTick();
            applyStimulus(161, 60, 1'b1, 12'h369);
            checkOutput($sformatf("bfade%0d_rgb", t), int'({red_b, green_b, blue_b}), int'(faded(12'hFA5, t / 2)));
            checkOutput($sformatf("bfade%0d_busy", t), int'(busy_b), (t < 32) ? 1 : 0);
        end
        for (int s = 1; s <= 9; s++) begin
            frameTick();
            applyStimulus(161, 60, 1'b1, 12'h369);
            checkOutput($sformatf("blink%0d_rgb", s), int'({red_b, green_b, blue_b}),
                        (((s / 3) % 2) == 0) ? int'(12'hFA5) : int'(12'h369));
        end
        checkOutput("blink_off_visible", int'(visible_b), 1);
        @(negedge vga_clk);
        show_b = 1'b0;
        applyStimulus(161, 60, 1'b1, 12'h369);
        checkOutput("blink_exit_rgb", int'({red_b, green_b, blue_b}), int'(12'hFA5));
        checkOutput("blink_exit_busy", int'(busy_b), 1);
        frameTick();
        applyStimulus(161, 60, 1'b1, 12'h369);
        checkOutput("bout1_rgb", int'({red_b, green_b, blue_b}), int'(12'hFA5));
        frameTick();
        applyStimulus(161, 60, 1'b1, 12'h369);
        checkOutput("bout2_rgb", int'({red_b, green_b, blue_b}), int'(faded(12'hFA5, 15)));

        $display("[TB] reset during fade-in");
        @(negedge vga_clk);
        show_m = 1'b1;
        for (int f = 1; f <= 3; f++) frameTick();
        applyStimulus(161, 60, 1'b1, 12'h5C7);
        checkOutput("prerst_rgb", int'({red_m, green_m, blue_m}), int'(faded(12'hFA5, 3)));
        checkOutput("prerst_busy", int'(busy_m), 1);
        @(negedge vga_clk);
        reset_n = 1'b0;
        show_m = 1'b0;
        @(negedge vga_clk);
        checkOutput("midrst_rgb", int'({red_m, green_m, blue_m}), 0);
        checkOutput("midrst_busy", int'(busy_m), 0);
        checkOutput("midrst_visible", int'(visible_m), 0);
        checkOutput("midrst_addr", int'(rom_addr_m), 0);
        reset_n = 1'b1;
        applyStimulus(161, 60, 1'b1, 12'h5C7);
        checkOutput("postrst_rgb", int'({red_m, green_m, blue_m}), int'(12'h5C7));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
